// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing the main system bus between the page walker and the caches.
// Grants are registered; the owner's request channel and response strobe are muxed combinationally.
module bus_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_TAG_WIDTH  = 13,
  parameter int unsigned GRANT_TIMEOUT  = 15,
  parameter int unsigned ID_WIDTH       = $clog2(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                abtr_reqcyc,
  input  logic [NUM_REQ-1:0]                bus_busy,
  output logic [NUM_REQ-1:0]                abtr_grant,
  output logic                              owner_valid,
  output logic [ID_WIDTH-1:0]               owner_id,
  input  logic [NUM_REQ-1:0]                m_reqcyc,
  input  logic [NUM_REQ*BUS_DATA_WIDTH-1:0] m_req,
  input  logic [NUM_REQ*BUS_TAG_WIDTH-1:0]  m_reqtag,
  input  logic [NUM_REQ-1:0]                m_respack,
  output logic [NUM_REQ-1:0]                m_respcyc,
  output logic                              main_bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0]         main_bus_req,
  output logic [BUS_TAG_WIDTH-1:0]          main_bus_reqtag,
  output logic                              main_bus_respack,
  input  logic                              main_bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0]         main_bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]          main_bus_resptag
);

  typedef enum logic [1:0] {StIdle, StGrant, StOwned, StRelease} state_e;

  state_e              state_q;
  logic [ID_WIDTH-1:0] last_owner_q;
  logic [7:0]          tmo_cnt_q;
  logic [7:0]          tmo_inc;

  logic                pick_found;
  logic [ID_WIDTH-1:0] pick_id;
  logic [ID_WIDTH-1:0] pick_idx;
  logic [NUM_REQ-1:0]  pick_grant;
  logic                owner_busy;
  logic                owner_req;

  // Response data and tag are broadcast at top level and do not pass through here.
  logic unused_resp;
  assign unused_resp = ^{main_bus_resp, main_bus_resptag};

  assign owner_busy = |(bus_busy & abtr_grant);
  assign owner_req  = |(abtr_reqcyc & abtr_grant);
  assign tmo_inc    = (tmo_cnt_q == 8'hFF) ? 8'hFF : tmo_cnt_q + 8'd1;

  // First requester strictly after the last owner, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    pick_idx   = '0;
    pick_grant = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      pick_idx = ID_WIDTH'((32'(last_owner_q) + i) % NUM_REQ);
      if (!pick_found && abtr_reqcyc[pick_idx]) begin
        pick_found           = 1'b1;
        pick_id              = pick_idx;
        pick_grant[pick_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      abtr_grant   <= '0;
      owner_valid  <= 1'b0;
      owner_id     <= '0;
      last_owner_q <= ID_WIDTH'(NUM_REQ - 1);
      tmo_cnt_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_found) begin
            abtr_grant  <= pick_grant;
            owner_id    <= pick_id;
            owner_valid <= 1'b1;
            tmo_cnt_q   <= '0;
            state_q     <= StGrant;
          end
        end
        StGrant: begin
          if (owner_busy) begin
            state_q <= StOwned;
          end else if (!owner_req || (tmo_inc >= 8'(GRANT_TIMEOUT))) begin
            abtr_grant  <= '0;
            owner_valid <= 1'b0;
            state_q     <= StRelease;
          end else begin
            tmo_cnt_q <= tmo_inc;
          end
        end
        StOwned: begin
          if (!owner_busy) begin
            abtr_grant  <= '0;
            owner_valid <= 1'b0;
            state_q     <= StRelease;
          end
        end
        StRelease: begin
          // owner_id still holds the departing master here.
          last_owner_q <= owner_id;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    main_bus_reqcyc  = 1'b0;
    main_bus_req     = '0;
    main_bus_reqtag  = '0;
    main_bus_respack = 1'b0;
    m_respcyc        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_valid && abtr_grant[i]) begin
        main_bus_reqcyc  = m_reqcyc[i];
        main_bus_req     = m_req[i*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
        main_bus_reqtag  = m_reqtag[i*BUS_TAG_WIDTH +: BUS_TAG_WIDTH];
        main_bus_respack = m_respack[i];
        m_respcyc[i]     = main_bus_respcyc;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: grant timing, round-robin order, muxing, timeout and async reset.
module tb_bus_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned DW = 64;
  localparam int unsigned TW = 13;
  localparam int unsigned IW = 2;

  logic           clk;
  logic           reset;
  logic [NR-1:0]  abtr_reqcyc;
  logic [NR-1:0]  bus_busy;
  logic [NR-1:0]  abtr_grant;
  logic           owner_valid;
  logic [IW-1:0]  owner_id;
  logic [NR-1:0]  m_reqcyc;
  logic [NR*DW-1:0] m_req;
  logic [NR*TW-1:0] m_reqtag;
  logic [NR-1:0]  m_respack;
  logic [NR-1:0]  m_respcyc;
  logic           main_bus_reqcyc;
  logic [DW-1:0]  main_bus_req;
  logic [TW-1:0]  main_bus_reqtag;
  logic           main_bus_respack;
  logic           main_bus_respcyc;
  logic [DW-1:0]  main_bus_resp;
  logic [TW-1:0]  main_bus_resptag;

  int n_cmp;
  int n_err;

  bus_arbiter #(
    .NUM_REQ       (NR),
    .BUS_DATA_WIDTH(DW),
    .BUS_TAG_WIDTH (TW),
    .GRANT_TIMEOUT (15),
    .ID_WIDTH      (IW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .abtr_reqcyc     (abtr_reqcyc),
    .bus_busy        (bus_busy),
    .abtr_grant      (abtr_grant),
    .owner_valid     (owner_valid),
    .owner_id        (owner_id),
    .m_reqcyc        (m_reqcyc),
    .m_req           (m_req),
    .m_reqtag        (m_reqtag),
    .m_respack       (m_respack),
    .m_respcyc       (m_respcyc),
    .main_bus_reqcyc (main_bus_reqcyc),
    .main_bus_req    (main_bus_req),
    .main_bus_reqtag (main_bus_reqtag),
    .main_bus_respack(main_bus_respack),
    .main_bus_respcyc(main_bus_respcyc),
    .main_bus_resp   (main_bus_resp),
    .main_bus_resptag(main_bus_resptag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    abtr_reqcyc      = '0;
    bus_busy         = '0;
    m_reqcyc         = '0;
    m_req            = '0;
    m_reqtag         = '0;
    m_respack        = '0;
    main_bus_respcyc = 1'b0;
    main_bus_resp    = '0;
    main_bus_resptag = '0;
  endtask

  logic [NR-1:0] rr_exp [4];

  initial begin
    n_cmp = 0;
    n_err = 0;
    rr_exp[0] = 4'b0001;
    rr_exp[1] = 4'b0010;
    rr_exp[2] = 4'b1000;
    rr_exp[3] = 4'b0001;
    reset = 1'b0;
    idle_inputs();

    // Reset state
    #2;
    check_val("rst_grant", 64'(abtr_grant), 64'h0);
    check_val("rst_valid", 64'(owner_valid), 64'h0);
    check_val("rst_id", 64'(owner_id), 64'h0);
    #10 reset = 1'b1;
    step();

    // Single master 2: one-cycle grant latency, held while busy, drop after busy falls
    abtr_reqcyc = 4'b0100;
    #1;
    check_val("t1_no_grant_yet", 64'(abtr_grant), 64'h0);
    step();
    check_val("t1_grant", 64'(abtr_grant), 64'h4);
    check_val("t1_id", 64'(owner_id), 64'h2);
    check_val("t1_valid", 64'(owner_valid), 64'h1);
    bus_busy = 4'b0100;
    step();
    abtr_reqcyc = 4'b0000;
    for (int i = 0; i < 7; i++) step();
    check_val("t1_hold_no_req", 64'(abtr_grant), 64'h4);
    bus_busy = 4'b0000;
    step();
    check_val("t1_drop_grant", 64'(abtr_grant), 64'h0);
    check_val("t1_drop_valid", 64'(owner_valid), 64'h0);
    // Mux outputs gated with no owner
    m_reqcyc = 4'b1111;
    m_respack = 4'b1111;
    main_bus_respcyc = 1'b1;
    #1;
    check_val("idle_reqcyc", 64'(main_bus_reqcyc), 64'h0);
    check_val("idle_respack", 64'(main_bus_respack), 64'h0);
    check_val("idle_respcyc", 64'(m_respcyc), 64'h0);
    step();
    check_val("t1_idle_valid", 64'(owner_valid), 64'h0);
    idle_inputs();

    // Round robin among 0,1,3 from reset
    #2 reset = 1'b0;
    #3 reset = 1'b1;
    step();
    abtr_reqcyc = 4'b1011;
    for (int r = 0; r < 4; r++) begin
      step();
      check_val($sformatf("rr%0d_grant", r), 64'(abtr_grant), 64'(rr_exp[r]));
      bus_busy = abtr_grant;
      step();
      check_val($sformatf("rr%0d_owned", r), 64'(abtr_grant), 64'(rr_exp[r]));
      bus_busy = '0;
      step();
      check_val($sformatf("rr%0d_release", r), 64'(owner_valid), 64'h0);
      step();
      check_val($sformatf("rr%0d_idle", r), 64'(owner_valid), 64'h0);
    end
    abtr_reqcyc = '0;
    step();

    // Muxing with owner 1 while master 0 drives conflicting data
    abtr_reqcyc = 4'b0010;
    step();
    check_val("mux_grant", 64'(abtr_grant), 64'h2);
    m_req[0*DW +: DW]    = 64'hDEAD;
    m_req[1*DW +: DW]    = 64'h1000;
    m_req[3*DW +: DW]    = 64'hBEEF;
    m_reqtag[0*TW +: TW] = 13'h1FFF;
    m_reqtag[1*TW +: TW] = 13'h1100;
    m_reqcyc  = 4'b0011;
    m_respack = 4'b0001;
    main_bus_respcyc = 1'b1;
    #1;
    check_val("mux_req", 64'(main_bus_req), 64'h1000);
    check_val("mux_tag", 64'(main_bus_reqtag), 64'h1100);
    check_val("mux_reqcyc", 64'(main_bus_reqcyc), 64'h1);
    check_val("mux_respack_other", 64'(main_bus_respack), 64'h0);
    check_val("mux_respcyc", 64'(m_respcyc), 64'h2);
    m_respack = 4'b0010;
    m_reqcyc  = 4'b0001;
    #1;
    check_val("mux_respack_own", 64'(main_bus_respack), 64'h1);
    check_val("mux_reqcyc_other", 64'(main_bus_reqcyc), 64'h0);
    idle_inputs();

    // Owner 1 abandons in GRANT; last_owner becomes 1, so 2 beats 1 next
    step();
    check_val("abandon_release", 64'(owner_valid), 64'h0);
    abtr_reqcyc = 4'b0110;
    step();
    step();
    check_val("abandon_next_grant", 64'(abtr_grant), 64'h4);

    // Owner 2 never raises busy: 15 cycles in GRANT, then release, grant to 1 two cycles later
    for (int i = 0; i < 14; i++) step();
    check_val("tmo_still_granted", 64'(abtr_grant), 64'h4);
    step();
    check_val("tmo_release", 64'(owner_valid), 64'h0);
    step();
    check_val("tmo_idle", 64'(owner_valid), 64'h0);
    step();
    check_val("tmo_next_grant", 64'(abtr_grant), 64'h2);
    check_val("tmo_next_id", 64'(owner_id), 64'h1);

    // Async reset while owner 1 is in OWNED
    bus_busy = 4'b0010;
    m_reqcyc = 4'b0010;
    step();
    #1;
    check_val("ar_reqcyc_before", 64'(main_bus_reqcyc), 64'h1);
    #1 reset = 1'b0;
    #1;
    check_val("ar_grant", 64'(abtr_grant), 64'h0);
    check_val("ar_reqcyc", 64'(main_bus_reqcyc), 64'h0);
    check_val("ar_valid", 64'(owner_valid), 64'h0);
    idle_inputs();
    #2 reset = 1'b1;
    abtr_reqcyc = 4'b1011;
    step();
    check_val("ar_first_grant", 64'(abtr_grant), 64'h1);
    check_val("ar_first_id", 64'(owner_id), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the single main system bus among NUM_REQ masters: page-table walker, instruction cache and data cache.
- Arbitrates with the abtr_reqcyc / abtr_grant / bus_busy handshake the masters already implement, using round-robin priority.
- While a master owns the bus, its request channel is muxed onto the bus and the response strobe is routed back to it.
- Sits between the masters and the top-level bus interface.

Parameters:
NUM_REQ, 4, number of masters; index 0 is the page walker.
BUS_DATA_WIDTH, 64, bus request/response data width.
BUS_TAG_WIDTH, 13, bus tag width.
GRANT_TIMEOUT, 15, max cycles between grant and owner raising busy; range 1..255.
ID_WIDTH, $clog2(NUM_REQ), width of owner index.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  reset, asynchronous, active-low.
abtr_reqcyc  in  NUM_REQ  per-master arbitration request.
bus_busy  in  NUM_REQ  per-master "transaction in progress".
abtr_grant  out  NUM_REQ  one-hot grant.
owner_valid  out  1  a master currently holds the grant.
owner_id  out  ID_WIDTH  index of the granted master.
m_reqcyc  in  NUM_REQ  per-master bus request strobe.
m_req  in  NUM_REQ*BUS_DATA_WIDTH  per-master request data; slice i belongs to master i.
m_reqtag  in  NUM_REQ*BUS_TAG_WIDTH  per-master request tag.
m_respack  in  NUM_REQ  per-master response acknowledge.
m_respcyc  out  NUM_REQ  response strobe, routed to the owner only.
main_bus_reqcyc  out  1  bus request strobe.
main_bus_req  out  BUS_DATA_WIDTH  bus request data.
main_bus_reqtag  out  BUS_TAG_WIDTH  bus request tag.
main_bus_respack  out  1  bus response acknowledge.
main_bus_respcyc  in  1  bus response strobe.
main_bus_resp  in  BUS_DATA_WIDTH  response data; broadcast unmodified to all masters at top level.
main_bus_resptag  in  BUS_TAG_WIDTH  response tag; broadcast unmodified to all masters at top level.

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE.
  - abtr_grant=0, owner_valid=0, owner_id=0.
  - last_owner=NUM_REQ-1, so master 0 wins first.
  - timeout counter=0.
- Combinational outputs are 0 when owner_valid=0: main_bus_reqcyc, main_bus_req, main_bus_reqtag, main_bus_respack, m_respcyc.
- States:
  - IDLE: if any abtr_reqcyc bit is set, select the first set bit searching from last_owner+1 upward, wrapping modulo NUM_REQ.
    - Register abtr_grant (one-hot), owner_id and owner_valid=1; go to GRANT.
    - Grant is visible exactly 1 cycle after the request is seen in IDLE.
  - GRANT:
    - bus_busy[owner]=1 -> OWNED.
    - Else abtr_reqcyc[owner]=0 -> RELEASE (request abandoned).
    - Else, timeout counter reaching GRANT_TIMEOUT -> RELEASE.
  - OWNED:
    - Grant held regardless of abtr_reqcyc[owner].
    - bus_busy[owner] falling to 0 -> RELEASE.
  - RELEASE:
    - abtr_grant=0, owner_valid=0; last_owner<=owner_id; go to IDLE.
    - Gives a 1-cycle bus turnaround; no new grant is issued in this cycle.
- Timeout counter: 8-bit, cleared on entry to GRANT, increments each cycle in GRANT, saturating. The grant timeout does not apply in OWNED.
- Muxing while owner_valid=1:
  - main_bus_reqcyc = m_reqcyc[owner]; main_bus_req and main_bus_reqtag = owner's slices.
  - main_bus_respack = m_respack[owner].
  - m_respcyc[owner] = main_bus_respcyc; all other bits 0.
- Non-owner m_reqcyc and m_respack are ignored. A main_bus_respcyc pulse with no owner is dropped.
- Simultaneous requests: only round-robin order decides; there are no fixed priorities.
- A request raised during GRANT, OWNED or RELEASE waits for IDLE.
- The same master may win consecutive grants only if no other master is requesting.
- Reset mid-transaction: grant and mux outputs drop immediately (asynchronously); the master must itself be reset.

Test Plan:
- Single master 2 raises abtr_reqcyc at cycle 0 -> abtr_grant=4'b0100, owner_id=2 at cycle 1; busy high cycles 2-9 then low -> grant drops one cycle after busy falls; owner_valid=0 for ≥1 cycle.
- Masters 0,1,3 all request from reset and hold requests -> grant order 0,1,3,0; each grant separated by one RELEASE cycle.
- Owner 1 drives m_req=64'h1000, m_reqtag=13'h1100, m_reqcyc=1; master 0 drives m_req=64'hDEAD -> main_bus_req=64'h1000, main_bus_reqtag=13'h1100; main_bus_respcyc pulse -> m_respcyc=4'b0010.
- Granted master never raises busy, keeps abtr_reqcyc=1 -> RELEASE after 15 cycles in GRANT; the next requester is granted 2 cycles later.
- Owner drops abtr_reqcyc in GRANT without busy -> release next cycle, last_owner updated.
- Assert reset low while in OWNED, asynchronously between edges -> abtr_grant=0, main_bus_reqcyc=0 immediately; after release, master 0 gets first grant.
